poly_staff: RTL and testbench
=============================

Name: poly_staff

Overview:
- Polyphonic successor to the single-channel keyboard-to-tone mapper.
- Consumes the registered PS/2 scan-code stream: make codes, F0 break prefix and E0 extended prefix.
- Tracks up to N_CH simultaneously held note keys and allocates each held key to a tone channel.
- Drives per-channel tone value and gate to the audio synthesiser, with a global octave-shift mode.

Parameters:
- N_CH, 4, number of tone channels (1..8).
- SOUND_W, 16, width of each channel tone value.
- IDLE_TONE, 1, tone value driven on a channel whose gate is 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
- scan_code  in  8  PS/2 scan-code byte.
- octave_sel  in  2  0 normal, 1 up (tone<<1), 2 down (tone>>1), 3 treated as 0.
- key_clear  in  1  synchronous release of all channels.
- sound  out  N_CH*SOUND_W  channel c tone at bits [c*SOUND_W +: SOUND_W].
- gate  out  N_CH  channel c active.
- sound_off  out  1  1 when no gate is set.
- overflow  out  1  one-cycle pulse when a make finds no free channel.

Behaviour:
- Reset (rst_n=0 at an edge): parser in IDLE; all channels free; sound = IDLE_TONE on every channel; gate=0; sound_off=1; overflow=0.
- Note map, 20 keys, note index 0..19, base tones:
  - 15→400, 1c→423, 1d→448, 1b→475, 24→503
  - 23→533, 2b→565, 2c→599, 34→634, 35→672
  - 33→712, 3b→755, 43→800, 42→847, 44→897
  - 4b→951, 4d→1007, 4c→1067, 52→1131, 5b→1198
  - Any other code is a non-note.
- Parser FSM, advancing only on scan_valid:
  - IDLE: F0→BRK; E0→EXT; note→make event; non-note→IDLE.
  - BRK: any code→IDLE; if a note, generate a break event.
  - EXT: F0→EXT_BRK; any other code→IDLE, ignored.
  - EXT_BRK: any code→IDLE, ignored.
  - Every extended sequence is discarded.
- Channel state per channel: busy bit plus 5-bit note index.
- Make event:
  - If any busy channel already holds the note (typematic repeat): no change.
  - Otherwise the lowest-numbered free channel takes it.
  - If no channel is free: state unchanged and overflow pulses on the next cycle.
- Break event: every busy channel holding that note is freed. A break for an unheld note is a no-op.
- key_clear: frees all channels at that edge and takes priority over a same-cycle event. The parser state is unaffected.
- Timing: channel state updates at the edge sampling scan_valid (edge k). sound, gate, sound_off and overflow are registered from channel state and update at edge k+1, giving a fixed 2-cycle latency from strobe to output.
- Output tone for a busy channel, from base tone t:
  - octave_sel=1: t<<1, truncated to SOUND_W.
  - octave_sel=2: t>>1.
  - Otherwise: t.
  - octave_sel changes apply to held notes with 1-cycle latency.
- Back-to-back strobes on consecutive cycles are fully supported. No input is dropped.
- Reset asserted mid-sequence (e.g. after F0) returns the parser to IDLE; the following code is treated as a fresh code.

Decomposition:
- Shared package/include holds:
  - Parser state encodings IDLE, BRK, EXT, EXT_BRK.
  - Prefix constants F0 and E0.
  - NOTE_W=5 and NUM_NOTES=20.
- Sub-module poly_staff_rom: combinational scan_code→{is_note, note_idx} and note_idx→base tone.
- The channel allocator and octave shift stay in the top level.

Test Plan:
- After reset, strobe 1c → two cycles later ch0 sound=423, gate=0001, sound_off=0.
- 1c then 2b → ch0=423, ch1=565, gate=0011. Then F0,1c → gate=0010, ch0=1, ch1=565.
- Four distinct makes 1c,2b,34,33 then 3b → gate=1111, overflow pulse exactly 1 cycle, ch0..3 unchanged (423,565,634,712).
- 2b held, octave_sel=1 → ch0=1130. octave_sel=2 → 282. octave_sel=3 → 565.
- 2b repeated five times → only ch0 busy. E0,1c and E0,F0,1c → no state change. Unknown code 0x76 → ignored.
- Three notes held, key_clear asserted in the same cycle as a make strobe → all gates 0, sound_off=1, and the make is dropped. Reset after F0, then strobe 1c → treated as a make, ch0=423.

Source files
------------

// File: rtl/poly_staff_pkg.sv
// Shared types and constants for the polyphonic keyboard-to-tone mapper.
package poly_staff_pkg;

    // PS/2 prefix bytes
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E0 = 8'hE0;

    // Note table geometry
    localparam int NOTE_W    = 5;
    localparam int NUM_NOTES = 20;

    // Base tones (largest is 1198) fit in 11 bits
    localparam int TONE_W = 11;

    typedef logic [NOTE_W-1:0] note_idx_t;

    // Scan-code parser states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_e;

endpackage

// File: rtl/poly_staff_rom.sv
// Combinational lookup tables: scan code to note index, note index to base tone.
module poly_staff_rom
    import poly_staff_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [7:0]             scan_code,
    output logic                   is_note,
    output note_idx_t              note_idx,
    input  logic [N_CH*NOTE_W-1:0] ch_note,
    output logic [N_CH*TONE_W-1:0] ch_tone
);

    function automatic logic [TONE_W-1:0] base_tone(input note_idx_t idx);
        case (idx)
            5'd0:    return 11'd400;
            5'd1:    return 11'd423;
            5'd2:    return 11'd448;
            5'd3:    return 11'd475;
            5'd4:    return 11'd503;
            5'd5:    return 11'd533;
            5'd6:    return 11'd565;
            5'd7:    return 11'd599;
            5'd8:    return 11'd634;
            5'd9:    return 11'd672;
            5'd10:   return 11'd712;
            5'd11:   return 11'd755;
            5'd12:   return 11'd800;
            5'd13:   return 11'd847;
            5'd14:   return 11'd897;
            5'd15:   return 11'd951;
            5'd16:   return 11'd1007;
            5'd17:   return 11'd1067;
            5'd18:   return 11'd1131;
            5'd19:   return 11'd1198;
            default: return '0;
        endcase
    endfunction

    // Classify the incoming byte and find its note index
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        is_note  = 1'b1;
        note_idx = '0;
        case (scan_code)
            8'h15:   note_idx = 5'd0;
            8'h1c:   note_idx = 5'd1;
            8'h1d:   note_idx = 5'd2;
            8'h1b:   note_idx = 5'd3;
            8'h24:   note_idx = 5'd4;
            8'h23:   note_idx = 5'd5;
            8'h2b:   note_idx = 5'd6;
            8'h2c:   note_idx = 5'd7;
            8'h34:   note_idx = 5'd8;
            8'h35:   note_idx = 5'd9;
            8'h33:   note_idx = 5'd10;
            8'h3b:   note_idx = 5'd11;
            8'h43:   note_idx = 5'd12;
            8'h42:   note_idx = 5'd13;
            8'h44:   note_idx = 5'd14;
            8'h4b:   note_idx = 5'd15;
            8'h4d:   note_idx = 5'd16;
            8'h4c:   note_idx = 5'd17;
            8'h52:   note_idx = 5'd18;
            8'h5b:   note_idx = 5'd19;
            default: is_note  = 1'b0;
        endcase
    end

    // Per-channel base tone of the held note
    always_comb begin
        ch_tone = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_tone[c*TONE_W +: TONE_W] = base_tone(ch_note[c*NOTE_W +: NOTE_W]);
        end
    end

endmodule

// File: rtl/poly_staff.sv
// Polyphonic PS/2 keyboard-to-tone mapper: parses make/break codes, allocates
// held notes to tone channels and drives registered per-channel tone and gate.
module poly_staff
    import poly_staff_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int SOUND_W   = 16,
    parameter int IDLE_TONE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_valid,
    input  logic [7:0]              scan_code,
    input  logic [1:0]              octave_sel,
    input  logic                    key_clear,
    output logic [N_CH*SOUND_W-1:0] sound,
    output logic [N_CH-1:0]         gate,
    output logic                    sound_off,
    output logic                    overflow
);

    parse_state_e                   state_q, state_d;
    logic                           is_note;
    note_idx_t                      code_idx;
    logic                           make_evt, brk_evt;

    logic [N_CH-1:0]                busy_q, busy_d;
    logic [N_CH-1:0][NOTE_W-1:0]    note_q, note_d;
    logic                           ovf_evt_q, ovf_evt_d;
    logic                           hit, found;

    logic [N_CH*TONE_W-1:0]         ch_tone;
    logic [N_CH-1:0][TONE_W:0]      shifted;
    logic [N_CH*SOUND_W-1:0]        sound_q, sound_d;
    logic [N_CH-1:0]                gate_q, gate_d;
    logic                           sound_off_q, sound_off_d;
    logic                           overflow_q, overflow_d;

    poly_staff_rom #(.N_CH(N_CH)) u_rom (
        .scan_code (scan_code),
        .is_note   (is_note),
        .note_idx  (code_idx),
        .ch_note   (note_q),
        .ch_tone   (ch_tone)
    );

    // Parser state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Parser next state; extended sequences are consumed and dropped
    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == CODE_F0)      state_d = ST_BRK;
                    else if (scan_code == CODE_E0) state_d = ST_EXT;
                end
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT:     state_d = (scan_code == CODE_F0) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Parser outputs: note make / break events for this strobe
    always_comb begin
        make_evt = scan_valid && (state_q == ST_IDLE) && is_note;
        brk_evt  = scan_valid && (state_q == ST_BRK)  && is_note;
    end

    // Channel allocator: clear beats events; repeats of a held note are ignored
    always_comb begin
        busy_d    = busy_q;
        note_d    = note_q;
        ovf_evt_d = 1'b0;
        hit       = 1'b0;
        found     = 1'b0;
        if (key_clear) begin
            busy_d = '0;
        end else if (make_evt) begin
            for (int c = 0; c < N_CH; c++) begin
                if (busy_q[c] && (note_q[c] == code_idx)) hit = 1'b1;
            end
            if (!hit) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (!found && !busy_q[c]) begin
                        busy_d[c] = 1'b1;
                        note_d[c] = code_idx;
                        found     = 1'b1;
                    end
                end
                ovf_evt_d = !found;
            end
        end else if (brk_evt) begin
            for (int c = 0; c < N_CH; c++) begin
                if (busy_q[c] && (note_q[c] == code_idx)) busy_d[c] = 1'b0;
            end
        end
    end

    // Output stage inputs: octave-shifted tone per busy channel, idle tone otherwise
    always_comb begin
        shifted = '0;
        sound_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            case (octave_sel)
                2'd1:    shifted[c] = {ch_tone[c*TONE_W +: TONE_W], 1'b0};
                2'd2:    shifted[c] = {2'b00, ch_tone[c*TONE_W+1 +: TONE_W-1]};
                default: shifted[c] = {1'b0, ch_tone[c*TONE_W +: TONE_W]};
            endcase
            sound_d[c*SOUND_W +: SOUND_W] = busy_q[c] ? SOUND_W'(shifted[c])
                                                      : SOUND_W'(IDLE_TONE);
        end
        gate_d      = busy_q;
        sound_off_d = ~|busy_q;
        overflow_d  = ovf_evt_q;
    end

    // Channel state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: note indices are only meaningful while busy, but they are small and cleared anyway to keep reset state fully defined.
            busy_q      <= '0;
            note_q      <= '0;
            ovf_evt_q   <= 1'b0;
            sound_q     <= {N_CH{SOUND_W'(IDLE_TONE)}};
            gate_q      <= '0;
            sound_off_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            note_q      <= note_d;
            ovf_evt_q   <= ovf_evt_d;
            sound_q     <= sound_d;
            gate_q      <= gate_d;
            sound_off_q <= sound_off_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sound     = sound_q;
    assign gate      = gate_q;
    assign sound_off = sound_off_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_poly_staff.sv
// Self-checking bench for poly_staff: directed test-plan steps followed by
// randomized scan-code traffic, compared every cycle against a behavioural model.
module tb_poly_staff;

    localparam int N_CH    = 4;
    localparam int SOUND_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    scan_valid;
    logic [7:0]              scan_code;
    logic [1:0]              octave_sel;
    logic                    key_clear;
    logic [N_CH*SOUND_W-1:0] sound;
    logic [N_CH-1:0]         gate;
    logic                    sound_off;
    logic                    overflow;

    always #5 clk = ~clk;

    poly_staff #(.N_CH(N_CH), .SOUND_W(SOUND_W), .IDLE_TONE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .octave_sel (octave_sel),
        .key_clear  (key_clear),
        .sound      (sound),
        .gate       (gate),
        .sound_off  (sound_off),
        .overflow   (overflow)
    );

    int tests = 0;
    int fails = 0;

    // Model: scan code held by each channel (-1 = free), parser prefix flags
    int held[N_CH];
    bit p_brk, p_ext, p_ext_brk, ovf_pend;

    logic [N_CH*SOUND_W-1:0] exp_sound;
    logic [N_CH-1:0]         exp_gate;
    logic                    exp_off;
    logic                    exp_ovf;

    int codes[23] = '{'h15, 'h1c, 'h1d, 'h1b, 'h24, 'h23, 'h2b, 'h2c, 'h34, 'h35,
                      'h33, 'h3b, 'h43, 'h42, 'h44, 'h4b, 'h4d, 'h4c, 'h52, 'h5b,
                      'hF0, 'hE0, 'h76};

    function automatic int tone_of(input int code);
        case (code)
            'h15: return 400;  'h1c: return 423;  'h1d: return 448;  'h1b: return 475;
            'h24: return 503;  'h23: return 533;  'h2b: return 565;  'h2c: return 599;
            'h34: return 634;  'h35: return 672;  'h33: return 712;  'h3b: return 755;
            'h43: return 800;  'h42: return 847;  'h44: return 897;  'h4b: return 951;
            'h4d: return 1007; 'h4c: return 1067; 'h52: return 1131; 'h5b: return 1198;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge with the given inputs
    task automatic model_edge(input bit rst, input bit v, input int code, input bit clr, input int oct);
        int mk, bk, free_c;
        bit already;
        if (rst) begin
            for (int c = 0; c < N_CH; c++) held[c] = -1;
            p_brk = 0; p_ext = 0; p_ext_brk = 0; ovf_pend = 0;
            exp_sound = {N_CH{16'd1}};
            exp_gate  = '0;
            exp_off   = 1'b1;
            exp_ovf   = 1'b0;
            return;
        end
        // Outputs registered at this edge reflect the state held before it
        for (int c = 0; c < N_CH; c++) begin
            int t, s;
            if (held[c] >= 0) begin
                t = tone_of(held[c]);
                s = (oct == 1) ? ((t * 2) % 65536) : (oct == 2) ? (t / 2) : t;
                exp_sound[c*SOUND_W +: SOUND_W] = SOUND_W'(s);
                exp_gate[c] = 1'b1;
            end else begin
                exp_sound[c*SOUND_W +: SOUND_W] = 16'd1;
                exp_gate[c] = 1'b0;
            end
        end
        exp_off  = (exp_gate == '0);
        exp_ovf  = ovf_pend;
        ovf_pend = 0;
        // Parse
        mk = -1; bk = -1;
        if (v) begin
            if (p_ext) begin
                if (!p_ext_brk && code == 'hF0) p_ext_brk = 1;
                else begin p_ext = 0; p_ext_brk = 0; end
            end else if (p_brk) begin
                p_brk = 0;
                if (tone_of(code) >= 0) bk = code;
            end else if (code == 'hF0) p_brk = 1;
            else if (code == 'hE0) p_ext = 1;
            else if (tone_of(code) >= 0) mk = code;
        end
        // Apply
        if (clr) begin
            for (int c = 0; c < N_CH; c++) held[c] = -1;
        end else if (mk >= 0) begin
            already = 0;
            free_c  = -1;
            for (int c = 0; c < N_CH; c++) if (held[c] == mk) already = 1;
            for (int c = N_CH - 1; c >= 0; c--) if (held[c] < 0) free_c = c;
            if (!already) begin
                if (free_c >= 0) held[free_c] = mk;
                else ovf_pend = 1;
            end
        end else if (bk >= 0) begin
            for (int c = 0; c < N_CH; c++) if (held[c] == bk) held[c] = -1;
        end
    endtask

    task automatic compare_outputs(input string where);
        check({where, ".sound"},     sound,              exp_sound);
        check({where, ".gate"},      64'(gate),          64'(exp_gate));
        check({where, ".sound_off"}, 64'(sound_off),     64'(exp_off));
        check({where, ".overflow"},  64'(overflow),      64'(exp_ovf));
    endtask

    task automatic step(input bit v, input int code, input bit clr = 1'b0);
        scan_valid = v;
        scan_code  = code[7:0];
        key_clear  = clr;
        model_edge(1'b0, v, code, clr, int'(octave_sel));
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        key_clear  = 1'b0;
        compare_outputs("step");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        scan_valid = 1'b0;
        key_clear  = 1'b0;
        model_edge(1'b1, 1'b0, 0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_outputs("reset");
    endtask

    function automatic logic [15:0] ch(input int c);
        return sound[c*SOUND_W +: SOUND_W];
    endfunction

    initial begin
        rst_n      = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        octave_sel = 2'd0;
        key_clear  = 1'b0;
        #2;

        // Reset state
        do_reset();
        check("rst_gate", 64'(gate), 64'(0));
        check("rst_off", 64'(sound_off), 64'(1));
        check("rst_ch0", 64'(ch(0)), 64'(1));

        // Single make: two-cycle latency
        step(1, 'h1c);
        check("lat1_gate", 64'(gate), 64'(0));
        step(0, 0);
        check("make_ch0", 64'(ch(0)), 64'(423));
        check("make_gate", 64'(gate), 64'(4'b0001));
        check("make_off", 64'(sound_off), 64'(0));

        // Second make then break of the first
        step(1, 'h2b);
        step(0, 0);
        check("two_ch1", 64'(ch(1)), 64'(565));
        check("two_gate", 64'(gate), 64'(4'b0011));
        step(1, 'hF0);
        step(1, 'h1c);
        step(0, 0);
        check("brk_gate", 64'(gate), 64'(4'b0010));
        check("brk_ch0", 64'(ch(0)), 64'(1));
        check("brk_ch1", 64'(ch(1)), 64'(565));

        // Fill all channels then overflow
        do_reset();
        step(1, 'h1c); step(1, 'h2b); step(1, 'h34); step(1, 'h33);
        step(1, 'h3b);
        check("full_gate", 64'(gate), 64'(4'b1111));
        step(0, 0);
        check("ovf_pulse", 64'(overflow), 64'(1));
        step(0, 0);
        check("ovf_end", 64'(overflow), 64'(0));
        check("full_ch0", 64'(ch(0)), 64'(423));
        check("full_ch3", 64'(ch(3)), 64'(712));

        // Octave shifts on a held note
        do_reset();
        step(1, 'h2b);
        step(0, 0);
        octave_sel = 2'd1; step(0, 0);
        check("oct_up", 64'(ch(0)), 64'(1130));
        octave_sel = 2'd2; step(0, 0);
        check("oct_down", 64'(ch(0)), 64'(282));
        octave_sel = 2'd3; step(0, 0);
        check("oct_3", 64'(ch(0)), 64'(565));
        octave_sel = 2'd0;

        // Typematic repeat, extended sequences and unknown code
        for (int i = 0; i < 4; i++) step(1, 'h2b);
        step(1, 'hE0); step(1, 'h1c);
        step(1, 'hE0); step(1, 'hF0); step(1, 'h1c);
        step(1, 'h76);
        step(0, 0); step(0, 0);
        check("rep_gate", 64'(gate), 64'(4'b0001));

        // key_clear beats a same-cycle make
        step(1, 'h1c); step(1, 'h34);
        step(1, 'h35, 1'b1);
        step(0, 0);
        check("clr_gate", 64'(gate), 64'(0));
        check("clr_off", 64'(sound_off), 64'(1));
        step(0, 0);
        check("clr_drop", 64'(gate), 64'(0));

        // Reset in the middle of a break sequence
        step(1, 'hF0);
        do_reset();
        step(1, 'h1c);
        step(0, 0);
        check("rstmid_ch0", 64'(ch(0)), 64'(423));
        check("rstmid_gate", 64'(gate), 64'(4'b0001));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int pick;
            if ($urandom_range(0, 9) == 0) octave_sel = 2'($urandom_range(0, 3));
            pick = codes[$urandom_range(0, 22)];
            step($urandom_range(0, 9) < 7, pick, $urandom_range(0, 39) == 0);
        end
        step(0, 0);
        step(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
